// File: rtl/ad9653_spi_pkg.sv
// Shared constants, state encoding and frame builder for the AD9653 SPI master.
package ad9653_spi_pkg;

  localparam int FRAME_BITS = 24;
  localparam int INSTR_BITS = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  // Instruction word is {R/W, W1W0=00 (one byte), A12..A0}; reads shift zeros in the data slot.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic rw,
                                                        input logic [12:0] addr,
                                                        input logic [7:0] wdata);
    return {rw, 2'b00, addr, (rw ? 8'h00 : wdata)};
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timer: tick_o fires on the last of every DIV enabled cycles; clr_i restarts the count.
module spi_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [7:0] LAST = 8'(DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/ad9653_spi_master.sv
// 3-wire SPI master for AD9653 register access (single-byte frames).
// Read support is built only when AD9653_SPI_MASTER_READ_EN is defined.
module ad9653_spi_master
  import ad9653_spi_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rw,
  input  logic [12:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        csb,
  output logic        sclk,
  output logic        sdio_o,
  output logic        sdio_oe,
  input  logic        sdio_i
);

  logic [1:0]            state_q, state_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [4:0]            bit_q, bit_d;
  logic sclk_q, sclk_d, csb_q, csb_d, sdo_q, sdo_d, oe_q, oe_d;
  logic busy_q, busy_d, done_q, done_d;
  logic accept, tick, rw_eff, oe_drop;

  assign accept = (state_q == ST_IDLE) && start;

  spi_tick_gen #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (accept),
    .en_i   (state_q != ST_IDLE),
    .tick_o (tick)
  );

`ifdef AD9653_SPI_MASTER_READ_EN
  logic       rd_q, rd_d;
  logic [7:0] rx_q, rx_d, rdata_q, rdata_d;

  assign rw_eff  = rw;
  assign oe_drop = rd_q;

  // Slave data is captured on the clk edge where sclk rises, during the data byte only.
  always_comb begin
    rd_d    = rd_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    if (accept) rd_d = rw;
    if (state_q == ST_SHIFT && tick && !sclk_q && rd_q && bit_q >= 5'(INSTR_BITS))
      rx_d = {rx_q[6:0], sdio_i};
    if (state_q == ST_GAP && tick && rd_q) rdata_d = rx_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= 1'b0;
      rx_q    <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      rd_q    <= rd_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
`else
  logic unused_rd;
  assign unused_rd = rw ^ sdio_i;
  assign rw_eff    = 1'b0;
  assign oe_drop   = 1'b0;
  assign rdata     = 8'h00;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    csb_d   = csb_q;
    sdo_d   = sdo_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        shreg_d = build_frame(rw_eff, addr, wdata);
        sdo_d   = shreg_d[FRAME_BITS-1];
        bit_d   = '0;
        sclk_d  = 1'b0;
        csb_d   = 1'b0;
        oe_d    = 1'b1;
        busy_d  = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: if (tick) begin
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d = 1'b0;
          if (bit_q == 5'(FRAME_BITS - 1)) begin
            state_d = ST_HOLD;
          end else begin
            bit_d   = bit_q + 5'd1;
            shreg_d = shreg_q << 1;
            sdo_d   = shreg_q[FRAME_BITS-2];
            // Turn the pin around once the instruction has gone out.
            if (oe_drop && bit_q == 5'(INSTR_BITS - 1)) oe_d = 1'b0;
          end
        end
      end
      ST_HOLD: if (tick) begin
        csb_d   = 1'b1;
        sdo_d   = 1'b0;
        oe_d    = 1'b0;
        state_d = ST_GAP;
      end
      default: if (tick) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        bit_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      csb_q   <= 1'b1;
      sdo_q   <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      csb_q   <= csb_d;
      sdo_q   <= sdo_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign csb     = csb_q;
  assign sclk    = sclk_q;
  assign sdio_o  = sdo_q;
  assign sdio_oe = oe_q;

endmodule

// File: tb/tb_ad9653_spi_master.sv
// Randomized self-checking bench: DIV=2 instance for frame/read/reset checks, DIV=3 for back-to-back.
module tb_ad9653_spi_master;

  localparam int DIV_A = 2;
  localparam int DIV_B = 3;
`ifdef AD9653_SPI_MASTER_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_a, rw_a, busy_a, done_a, csb_a, sclk_a, sdo_a, oe_a, sdi_a;
  logic [12:0] addr_a;
  logic [7:0]  wdata_a, rdata_a;
  logic        start_b, rw_b, busy_b, done_b, csb_b, sclk_b, sdo_b, oe_b, sdi_b;
  logic [12:0] addr_b;
  logic [7:0]  wdata_b, rdata_b;

  ad9653_spi_master #(.DIV(DIV_A)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .rw(rw_a), .addr(addr_a), .wdata(wdata_a),
    .busy(busy_a), .done(done_a), .rdata(rdata_a), .csb(csb_a), .sclk(sclk_a),
    .sdio_o(sdo_a), .sdio_oe(oe_a), .sdio_i(sdi_a)
  );

  ad9653_spi_master #(.DIV(DIV_B)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .rw(rw_b), .addr(addr_b), .wdata(wdata_b),
    .busy(busy_b), .done(done_b), .rdata(rdata_b), .csb(csb_b), .sclk(sclk_b),
    .sdio_o(sdo_b), .sdio_oe(oe_b), .sdio_i(sdi_b)
  );

  int vecs = 0;
  int errs = 0;
  logic [7:0] rdata_exp = 8'h00;

  // Observer + slave for instance A: counts what happened on the pins since the last clear.
  int csb_lo = 0, csb_lo_last = 0, oe_cnt = 0, rises = 0, falls = 0;
  int done_cnt = 0, csb_falls = 0, outside_bad = 0;
  logic [23:0] cap = '0;
  logic sclk_p = 1'b0, csb_p = 1'b1;
  logic [7:0] sbyte = 8'h00;

  always @(negedge clk) begin
    if (!csb_a) begin
      csb_lo++;
      if (oe_a) oe_cnt++;
    end else if (oe_a || sdo_a || sclk_a) begin
      outside_bad++;
    end
    if (!csb_a && csb_p) csb_falls++;
    if (csb_a && !csb_p) csb_lo_last = csb_lo;
    if (sclk_a && !sclk_p && !csb_a) begin
      cap = {cap[22:0], sdo_a};
      rises++;
    end
    if (!sclk_a && sclk_p && !csb_a) falls++;
    if (done_a) done_cnt++;
    sclk_p = sclk_a;
    csb_p  = csb_a;
    sdi_a  = (falls >= 16 && falls < 24) ? sbyte[23 - falls] : 1'b0;
  end

  // Observer for instance B: csb low-run lengths and high gaps between frames.
  int lo_run_b = 0, hi_run_b = 0, lo_bad_b = 0, falls_b = 0, dones_b = 0, min_gap_b = 1000;
  logic csb_pb = 1'b1, seen_b = 1'b0;

  always @(negedge clk) begin
    if (!csb_b) begin
      if (csb_pb) begin
        falls_b++;
        if (seen_b && hi_run_b < min_gap_b) min_gap_b = hi_run_b;
        hi_run_b = 0;
      end
      lo_run_b++;
    end else begin
      if (!csb_pb) begin
        if (lo_run_b != 49 * DIV_B) lo_bad_b++;
        lo_run_b = 0;
        seen_b   = 1'b1;
      end
      hi_run_b++;
    end
    if (done_b) dones_b++;
    csb_pb = csb_b;
  end

  task automatic clear_mon();
    csb_lo = 0; csb_lo_last = 0; oe_cnt = 0; rises = 0; falls = 0;
    done_cnt = 0; csb_falls = 0; outside_bad = 0; cap = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_a = 1'b0; rw_a = 1'b0; addr_a = '0; wdata_a = '0;
    start_b = 1'b0; rw_b = 1'b0; addr_b = '0; wdata_b = '0; sdi_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if ({csb_a, sclk_a, sdo_a, oe_a, busy_a, done_a} !== 6'b100000) begin
      errs++; $display("FAIL reset_pins: got %b want 100000", {csb_a, sclk_a, sdo_a, oe_a, busy_a, done_a});
    end
    vecs++;
    if (rdata_a !== 8'h00) begin errs++; $display("FAIL reset_rdata: got %h want 00", rdata_a); end
    vecs++;
    if ({csb_b, sclk_b, oe_b, busy_b} !== 4'b1000) begin
      errs++; $display("FAIL reset_pins_b: got %b want 1000", {csb_b, sclk_b, oe_b, busy_b});
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input logic rw, input logic [12:0] addr, input logic [7:0] wd,
                        input logic [7:0] sb);
    logic        exp_rw;
    logic [23:0] exp_frame;
    int          exp_oe;
    exp_rw    = READ_EN ? rw : 1'b0;
    exp_frame = {exp_rw, 2'b00, addr, (exp_rw ? 8'h00 : wd)};
    exp_oe    = exp_rw ? 32 * DIV_A : 49 * DIV_A;
    clear_mon();
    sbyte = sb;
    rw_a = rw; addr_a = addr; wdata_a = wd; start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    rw_a = 1'($urandom); addr_a = 13'($urandom); wdata_a = 8'($urandom);
    vecs++;
    if ({busy_a, csb_a, sdo_a} !== {1'b1, 1'b0, exp_frame[23]}) begin
      errs++; $display("FAIL frame_start: got %b want %b", {busy_a, csb_a, sdo_a}, {1'b1, 1'b0, exp_frame[23]});
    end
    for (int i = 0; i < 400 && done_cnt == 0; i++) @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    if (exp_rw) rdata_exp = sb;
    vecs++;
    if (done_cnt !== 1) begin errs++; $display("FAIL done_count: got %0d want 1", done_cnt); end
    vecs++;
    if (cap !== exp_frame || rises !== 24) begin
      errs++; $display("FAIL frame_bits: got %h/%0d rises want %h/24", cap, rises, exp_frame);
    end
    vecs++;
    if (csb_lo_last !== 49 * DIV_A) begin
      errs++; $display("FAIL csb_low_len: got %0d want %0d", csb_lo_last, 49 * DIV_A);
    end
    vecs++;
    if (oe_cnt !== exp_oe) begin errs++; $display("FAIL oe_len: got %0d want %0d", oe_cnt, exp_oe); end
    vecs++;
    if (rdata_a !== rdata_exp) begin errs++; $display("FAIL rdata: got %h want %h", rdata_a, rdata_exp); end
    vecs++;
    if (outside_bad !== 0 || busy_a !== 1'b0) begin
      errs++; $display("FAIL idle_pins: got %0d bad/busy %b want 0/0", outside_bad, busy_a);
    end
  endtask

  task automatic test_directed();
    do_txn(1'b0, 13'h014, 8'hA5, 8'h00);
    do_txn(1'b1, 13'h001, 8'h00, 8'hC3);
    do_txn(1'b1, 13'h008, 8'h3C, 8'h96);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++)
      do_txn(1'($urandom_range(0, 1)), 13'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic test_start_ignored();
    logic [23:0] exp_frame;
    logic [12:0] a;
    logic [7:0]  d;
    a = 13'($urandom); d = 8'($urandom);
    exp_frame = {1'b0, 2'b00, a, d};
    clear_mon();
    rw_a = 1'b0; addr_a = a; wdata_a = d; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rw_a = 1'b1; addr_a = ~a; wdata_a = ~d; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int i = 0; i < 400 && done_cnt == 0; i++) @(posedge clk);
    repeat (200) @(posedge clk);
    #1;
    vecs++;
    if (done_cnt !== 1 || csb_falls !== 1) begin
      errs++; $display("FAIL busy_start: got %0d done %0d frames want 1 1", done_cnt, csb_falls);
    end
    vecs++;
    if (cap !== exp_frame) begin errs++; $display("FAIL busy_frame: got %h want %h", cap, exp_frame); end
  endtask

  task automatic test_reset_abort();
    clear_mon();
    sbyte = 8'h5A;
    rw_a = 1'b1; addr_a = 13'($urandom); wdata_a = 8'h00; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int i = 0; i < 400 && rises < 11; i++) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    vecs++;
    if ({csb_a, sclk_a, oe_a, busy_a, done_a} !== 5'b10000) begin
      errs++; $display("FAIL abort_pins: got %b want 10000", {csb_a, sclk_a, oe_a, busy_a, done_a});
    end
    rdata_exp = 8'h00;
    vecs++;
    if (rdata_a !== rdata_exp) begin errs++; $display("FAIL abort_rdata: got %h want 00", rdata_a); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    vecs++;
    if (done_cnt !== 0 || rdata_a !== 8'h00) begin
      errs++; $display("FAIL abort_done: got %0d done rdata %h want 0 00", done_cnt, rdata_a);
    end
  endtask

  task automatic test_back_to_back();
    int pre_dones;
    pre_dones = dones_b;
    rw_b = 1'b0; addr_b = 13'($urandom); wdata_b = 8'($urandom); start_b = 1'b1;
    repeat (470) @(posedge clk);
    #1;
    start_b = 1'b0;
    for (int i = 0; i < 400 && busy_b; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    vecs++;
    if (falls_b < 3) begin errs++; $display("FAIL b2b_frames: got %0d want >=3", falls_b); end
    vecs++;
    if (dones_b - pre_dones !== falls_b) begin
      errs++; $display("FAIL b2b_done: got %0d want %0d", dones_b - pre_dones, falls_b);
    end
    vecs++;
    if (min_gap_b < DIV_B) begin errs++; $display("FAIL b2b_gap: got %0d want >=%0d", min_gap_b, DIV_B); end
    vecs++;
    if (lo_bad_b !== 0 || busy_b !== 1'b0) begin
      errs++; $display("FAIL b2b_len: got %0d bad/busy %b want 0/0", lo_bad_b, busy_b);
    end
    vecs++;
    if (rdata_b !== 8'h00) begin errs++; $display("FAIL b2b_rdata: got %h want 00", rdata_b); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    do_txn(1'b1, 13'($urandom), 8'h00, 8'hE7);
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ad9653_spi_master.md
AD9653_SPI_MASTER -- requirements
Module: ad9653_spi_master

Interface
REQ-001 SHALL have parameter DIV, default 4, giving the SCLK half-period in clk cycles; legal range 2..255.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset; asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, a transaction request, sampled only in IDLE.
REQ-005 SHALL have port rw, input, 1: 1 means read, 0 means write.
REQ-006 SHALL have port addr, input, 13, the register address A12..A0.
REQ-007 SHALL have port wdata, input, 8, the write data byte.
REQ-008 SHALL have port busy, output, 1, high from start acceptance until done.
REQ-009 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-010 SHALL have port rdata, output, 8, the last read byte, held until the next read completes.
REQ-011 SHALL have port csb, output, 1, the chip select, active low.
REQ-012 SHALL have port sclk, output, 1, the serial clock, idle low.
REQ-013 SHALL have ports sdio_o (output, 1) and sdio_oe (output, 1), the serial data out and its output enable (1 = drive).
REQ-014 SHALL have port sdio_i, input, 1, the serial data in, from the pad.

Function
REQ-015 SHALL latch rw, addr and wdata when start=1 in IDLE; start while busy=1 SHALL be ignored.
REQ-016 SHALL form a 24-bit MSB-first frame: {rw, 2'b00 (W1W0, one byte), addr, data}; for reads, data = 8'h00.
REQ-017 SHALL run states IDLE -> SHIFT -> HOLD -> GAP -> IDLE.
REQ-018 SHALL, on the cycle after acceptance, assert csb=0 and busy=1, enter SHIFT and present frame bit 23 on sdio_o.
REQ-019 Each bit period in SHIFT SHALL be sclk low for DIV cycles, then sclk high for DIV cycles; sdio_o SHALL change only when sclk goes low.
REQ-020 After 24 bit periods the block SHALL drive sclk low and enter HOLD for DIV cycles with csb=0, so csb is low for exactly 49*DIV cycles.
REQ-021 On leaving HOLD the block SHALL set csb=1 and enter GAP for DIV cycles.
REQ-022 On leaving GAP the block SHALL pulse done=1 for one cycle, drive busy=0 in that same cycle, and return to IDLE.
REQ-023 For writes, sdio_oe SHALL be 1 for the whole csb-low interval.
REQ-024 For reads, sdio_oe SHALL be 1 for bits 23..8 and SHALL go 0 at the sclk falling edge ending bit 8; it SHALL stay 0 through HOLD and GAP.
REQ-025 For reads, the block SHALL sample sdio_i on the clk edge at which sclk rises, for bits 7..0, MSB first.
REQ-026 rdata SHALL update on the done cycle of a read only; writes SHALL NOT change rdata.
REQ-027 Outside a frame, sdio_oe SHALL be 0 and sdio_o SHALL be 0.
REQ-028 A start asserted in the done cycle SHALL be accepted, giving back-to-back frames with at least DIV cycles of csb high between them.

Reset
REQ-029 rst SHALL force, asynchronously: state IDLE, csb=1, sclk=0, sdio_o=0, sdio_oe=0, busy=0, done=0, rdata=8'h00, and all counters to 0.
REQ-030 rst mid-frame SHALL abort the frame immediately; no done pulse SHALL be issued and rdata SHALL read 8'h00.

Configuration
REQ-031 Macro AD9653_SPI_MASTER_READ_EN defined: full read support as specified above.
REQ-032 Macro AD9653_SPI_MASTER_READ_EN undefined: rw SHALL be ignored and frame bit 23 forced to 0; sdio_oe SHALL stay 1 for the whole frame; the sdio_i sampling logic SHALL be absent; rdata SHALL be constant 8'h00.

Structure
REQ-033 Package ad9653_spi_pkg SHALL hold FRAME_BITS=24, INSTR_BITS=16 and the state encoding {IDLE, SHIFT, HOLD, GAP}.
REQ-034 Sub-module spi_tick_gen (DIV-cycle half-period counter with a tick output, cleared on frame start) SHALL generate all sclk and state timing.

Verification
REQ-035 DIV=2, write addr=13'h014, wdata=8'hA5: bits 24'h0014A5 appear on sdio_o at the sclk rising edges; csb is low for 98 cycles; done is pulsed once; rdata is unchanged.
REQ-036 DIV=2, read addr=13'h001, with a slave model returning 8'hC3: instruction 16'h8001 is shifted out; sdio_oe falls after the 16th rising edge; rdata=8'hC3 at done.
REQ-037 Pulse start 10 cycles into a frame: no second frame is started; exactly one done pulse occurs.
REQ-038 Assert rst at bit 12 of a read: csb=1, sclk=0 and sdio_oe=0 immediately; no done pulse; rdata=8'h00.
REQ-039 Hold start=1 continuously with DIV=3: consecutive frames have csb high for at least 3 cycles between them, and done pulses once per frame.
REQ-040 With AD9653_SPI_MASTER_READ_EN undefined, rw=1 to addr=13'h008: bit 23 is 0; sdio_oe stays 1 for the whole frame; rdata stays 8'h00.
